// File: rtl/fir_pkg.sv
// Shared defaults, FSM state encoding and a width helper for the FIR stream scheduler.
package fir_pkg;

  localparam int DEF_INPUT_WIDTH  = 16;
  localparam int DEF_OUTPUT_WIDTH = 38;
  localparam int DEF_COEFF_SIZE   = 64;
  localparam int DEF_WATCHDOG     = 80;
  // fir_counter from the datapath is a fixed 6-bit tap index.
  localparam int FIR_COUNTER_W    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } fir_state_e;

  // clog2 that never returns 0, so degenerate parameter values still give a usable width.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: synchronous write, asynchronous (combinational) read,
// asynchronous clear. Out-of-range addresses never write and read back as zero.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int WIDTH   = DEF_INPUT_WIDTH,
  parameter int DEPTH   = DEF_COEFF_SIZE,
  parameter int WADDR_W = clog2_min1(DEF_COEFF_SIZE),
  parameter int RADDR_W = FIR_COUNTER_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [WADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [RADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]   rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, one entry written per enabled edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_i && (32'(wr_addr_i) == i)) begin
          mem_q[i] <= wr_data_i;
        end
      end
    end
  end

  // Read mux: the read index may be wider than the bank, so compare explicitly.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(rd_addr_i) == i) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/fir_stream_scheduler.sv
// Sequences one input sample at a time into an external FIR datapath, holds the
// result for the transmit side, and guards each sample with a BUSY-cycle watchdog.
//
// state | meaning
// IDLE  | ready for a sample (unless a result is still waiting); coefficient writes allowed
// ISSUE | one-cycle fir_input_valid strobe to the datapath
// BUSY  | waiting for fir_output_valid; watchdog running
module fir_stream_scheduler
  import fir_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int COEFF_SIZE   = DEF_COEFF_SIZE,
  parameter int WATCHDOG     = DEF_WATCHDOG,
  localparam int ADDR_W      = clog2_min1(COEFF_SIZE)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_WIDTH-1:0]   in_data,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [INPUT_WIDTH-1:0]   cfg_data,
  output logic                     fir_input_valid,
  output logic [INPUT_WIDTH-1:0]   fir_input,
  output logic [INPUT_WIDTH-1:0]   fir_coeff,
  input  logic                     fir_output_valid,
  input  logic [FIR_COUNTER_W-1:0] fir_counter,
  input  logic [OUTPUT_WIDTH-1:0]  fir_output,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUTPUT_WIDTH-1:0]  out_data,
  output logic                     cfg_err,
  output logic                     wdt_err
);

  localparam int               WDT_W    = clog2_min1(WATCHDOG);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WATCHDOG - 1);
  localparam logic [WDT_W-1:0] WDT_MAX  = {WDT_W{1'b1}};

  fir_state_e              state_q, state_d;
  logic [INPUT_WIDTH-1:0]  fir_input_q, fir_input_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [WDT_W-1:0]        wdt_q, wdt_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    wdt_err_q, wdt_err_d;

  logic accept;
  logic addr_ok;
  logic bank_we;

  assign in_ready = (state_q == IDLE) && !out_valid_q;
  assign accept   = in_valid && in_ready;
  assign addr_ok  = 32'(cfg_addr) < COEFF_SIZE;
  // A write in the same IDLE cycle as a sample acceptance still lands.
  assign bank_we  = cfg_we && (state_q == IDLE) && addr_ok;

  assign fir_input_valid = (state_q == ISSUE);
  assign fir_input       = fir_input_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign cfg_err         = cfg_err_q;
  assign wdt_err         = wdt_err_q;

  fir_coeff_bank #(
    .WIDTH   (INPUT_WIDTH),
    .DEPTH   (COEFF_SIZE),
    .WADDR_W (ADDR_W),
    .RADDR_W (FIR_COUNTER_W)
  ) u_bank (
    .clk_i     (clock),
    .rst_ni    (reset),
    .wr_en_i   (bank_we),
    .wr_addr_i (cfg_addr),
    .wr_data_i (cfg_data),
    .rd_addr_i (fir_counter),
    .rd_data_o (fir_coeff)
  );

  // Next-state logic: FSM, result holding register, watchdog and error pulses.
  always_comb begin
    state_d     = state_q;
    fir_input_d = fir_input_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wdt_d       = wdt_q;
    wdt_err_d   = 1'b0;
    cfg_err_d   = cfg_we && ((state_q != IDLE) || !addr_ok);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        wdt_d = '0;
        if (accept) begin
          fir_input_d = in_data;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wdt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        // A result arriving on the expiry cycle wins over the watchdog.
        if (fir_output_valid) begin
          out_data_d  = fir_output;
          out_valid_d = 1'b1;
          wdt_d       = '0;
          state_d     = IDLE;
        end else if (wdt_q == WDT_LAST) begin
          wdt_err_d = 1'b1;
          wdt_d     = '0;
          state_d   = IDLE;
        end else if (wdt_q != WDT_MAX) begin
          wdt_d = wdt_q + 1'b1;
        end
      end
      default: begin
        wdt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight sample and pending result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      fir_input_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wdt_q       <= '0;
      cfg_err_q   <= 1'b0;
      wdt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fir_input_q <= fir_input_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wdt_q       <= wdt_d;
      cfg_err_q   <= cfg_err_d;
      wdt_err_q   <= wdt_err_d;
    end
  end

endmodule

// File: doc/fir_stream_scheduler.md
FIR_STREAM_SCHEDULER -- requirements
Module: fir_stream_scheduler

Interface
REQ-001 Parameter INPUT_WIDTH, default 16, sets the sample and coefficient width.
REQ-002 Parameter OUTPUT_WIDTH, default 38, sets the FIR result width.
REQ-003 Parameter COEFF_SIZE, default 64, sets the tap count; ADDR_W = clog2(COEFF_SIZE).
REQ-004 Parameter WATCHDOG, default 80, sets the maximum number of BUSY cycles allowed per sample.
REQ-005 Port clock, input, 1: the single clock; all logic is rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port in_valid/in_ready/in_data, input/output/input, 1/1/INPUT_WIDTH: sample stream from the UART receive side.
REQ-008 Port cfg_we/cfg_addr/cfg_data, input, 1/ADDR_W/INPUT_WIDTH: coefficient write port.
REQ-009 Port fir_input_valid/fir_input/fir_coeff, output, 1/INPUT_WIDTH/INPUT_WIDTH: drive to the FIR datapath.
REQ-010 Port fir_output_valid/fir_counter/fir_output, input, 1/6/OUTPUT_WIDTH: status and result from the FIR datapath.
REQ-011 Port out_valid/out_ready/out_data, output/input/output, 1/1/OUTPUT_WIDTH: result stream to the UART transmit side.
REQ-012 Port cfg_err, output, 1: one-cycle pulse when a coefficient write is rejected.
REQ-013 Port wdt_err, output, 1: one-cycle pulse when the watchdog expires.

Function
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and BUSY.
REQ-015 in_ready SHALL be high only in IDLE with out_valid low.
REQ-016 On an accepted sample (in_valid&in_ready) at cycle T, the sample SHALL be latched into fir_input and the FSM SHALL enter ISSUE at T+1.
REQ-017 In ISSUE, fir_input_valid SHALL be 1 for exactly one cycle, then the FSM SHALL enter BUSY.
REQ-018 fir_input SHALL hold its value until the next accepted sample.
REQ-019 fir_coeff SHALL equal bank[fir_counter] combinationally in every state.
REQ-020 In BUSY, fir_output_valid SHALL capture fir_output into out_data, set out_valid, and move the FSM to IDLE in the next cycle.
REQ-021 out_valid SHALL stay high with out_data stable until out_ready is sampled high; it SHALL clear the cycle after.
REQ-022 fir_output_valid outside BUSY SHALL be ignored.
REQ-023 The watchdog SHALL count BUSY cycles from 0; at count WATCHDOG-1 without fir_output_valid, it SHALL pulse wdt_err, drop the sample and return to IDLE.
REQ-024 If fir_output_valid and watchdog expiry coincide, the result SHALL be captured and wdt_err SHALL stay low.
REQ-025 A cfg_we in IDLE SHALL write cfg_data to bank[cfg_addr] at that edge, including in the same cycle as a sample acceptance.
REQ-026 A cfg_we in ISSUE or BUSY SHALL not write and SHALL pulse cfg_err the next cycle.
REQ-027 A cfg_addr >= COEFF_SIZE SHALL not write and SHALL pulse cfg_err.
REQ-028 No arithmetic is performed: data is passed through and widths are preserved; the watchdog counter SHALL be clog2(WATCHDOG) bits wide and SHALL saturate.

Reset
REQ-029 While reset is low, the FSM SHALL be IDLE and the following SHALL be 0: fir_input_valid, fir_input, out_valid, out_data, cfg_err, wdt_err, the watchdog count and all bank entries.
REQ-030 Reset asserted mid-transaction SHALL discard the in-flight sample and any pending output with no further output pulse.

Structure
REQ-031 Package fir_pkg SHALL hold the width and size defaults and the state enum (IDLE, ISSUE, BUSY).
REQ-032 The coefficient register file SHALL be the sub-module fir_coeff_bank: sync write, async read, async clear.

Verification
REQ-033 Reset low, then high -> all outputs 0, in_ready=1, fir_coeff=0 for any fir_counter.
REQ-034 Write bank[5]=16'h1234, then fir_counter=5 -> fir_coeff=16'h1234.
REQ-035 Accept sample 16'h00FF at T -> fir_input_valid=1 only at T+1; model fir_output_valid at T+66 with value 38'h5 -> out_valid=1 and out_data=5, held while out_ready=0.
REQ-036 cfg_we during BUSY with addr 3 -> bank[3] unchanged and cfg_err pulse.
REQ-037 No fir_output_valid for 80 BUSY cycles -> wdt_err pulse and IDLE; a sample sent with out_valid high -> in_ready stays 0.
REQ-038 Assert reset during BUSY -> out_valid stays 0 after release and a late fir_output_valid is ignored.
